// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port arbiter in front of a single shared RAM
module ram_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] add_a,
  input  logic [ADDR_W-1:0] add_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic gnt, last, pick, sel_we;
  logic [ADDR_W-1:0] sel_add;
  logic [DATA_W-1:0] sel_wdata;
  // on contention the port not granted last time wins; otherwise whoever asks
  assign pick = (req_a & req_b) ? ~last : req_b;
  assign sel_we = pick ? we_b : we_a;
  assign sel_add = pick ? add_b : add_a;
  assign sel_wdata = pick ? wdata_b : wdata_a;
  assign busy = state != IDLE;
  // grant in IDLE, drive the RAM strobes in ACCESS, pulse ack in RESP
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      gnt <= 1'b0;
      last <= 1'b1;
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      rdata_a <= '0;
      rdata_b <= '0;
      ram_wr <= 1'b0;
      ram_rd <= 1'b0;
      ram_add <= '0;
      ram_data_in <= '0;
    end else
      case (state)
        IDLE:
          if (req_a | req_b) begin
            state <= ACCESS;
            gnt <= pick;
            last <= pick;
            ram_wr <= sel_we;
            ram_rd <= ~sel_we;
            ram_add <= sel_add;
            ram_data_in <= sel_we ? sel_wdata : '0;
          end
        ACCESS: begin
          state <= RESP;
          if (ram_rd & ~gnt) rdata_a <= ram_data_out;
          if (ram_rd & gnt) rdata_b <= ram_data_out;
          ram_wr <= 1'b0;
          ram_rd <= 1'b0;
          ram_add <= '0;
          ram_data_in <= '0;
          ack_a <= ~gnt;
          ack_b <= gnt;
        end
        RESP: begin
          state <= IDLE;
          ack_a <= 1'b0;
          ack_b <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: data width of the shared RAM.
REQ-002 Parameter ADDR_W, default 3: address width; 8 locations.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_a, req_b  input  1 each  access request from port A / port B; held high until the matching ack.
REQ-006 we_a, we_b  input  1 each  1 = write, 0 = read; sampled with the request.
REQ-007 add_a, add_b  input  ADDR_W each  target address.
REQ-008 wdata_a, wdata_b  input  DATA_W each  write data.
REQ-009 ack_a, ack_b  output  1 each  one-cycle completion pulse.
REQ-010 rdata_a, rdata_b  output  DATA_W each  registered read result per port.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 ram_wr, ram_rd  output  1 each  write and read strobes to the shared RAM.
REQ-013 ram_add  output  ADDR_W  RAM address.
REQ-014 ram_data_in  output  DATA_W  RAM write data.
REQ-015 ram_data_out  input  DATA_W  RAM read data; combinational from ram_add while ram_rd=1.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-017 IDLE: requests are sampled only here; with no request the FSM stays in IDLE.
REQ-018 IDLE, exactly one request high: that port is granted, its we/add/wdata are latched, next state is ACCESS.
REQ-019 IDLE, both requests high: the port not granted most recently wins (round-robin).
- The last-grant pointer updates on every grant.
REQ-020 ACCESS lasts one cycle.
- ram_add = latched address.
- Write: ram_wr=1, ram_rd=0, ram_data_in = latched wdata; the RAM commits at the end of the cycle.
- Read: ram_rd=1, ram_wr=0; ram_data_out is captured into the granted port's rdata register at the end of the cycle.
- Next state is RESP.
REQ-021 RESP lasts one cycle.
- The granted port's ack is 1 for exactly this cycle.
- Next state is IDLE.
REQ-022 Outside ACCESS: ram_wr=0, ram_rd=0, ram_add=0, ram_data_in=0.
REQ-023 Latency: request high in IDLE at edge N gives ACCESS in cycle N+1 and ack in cycle N+2.
- Minimum spacing between grants is 3 cycles.
REQ-024 A request high during ACCESS or RESP is ignored until IDLE.
- A request still high in the IDLE cycle after its own ack is treated as a new transaction.
REQ-025 rdata_x changes only on completion of a read by port x.
- It is unchanged by writes and by the other port's accesses.
REQ-026 ack_a and ack_b are never high in the same cycle.
- Never more than one RAM strobe is high.
REQ-027 A request dropped before its grant is forgotten, with no side effect.

Reset
REQ-028 While rst=1, immediately and independent of clk:
- state = IDLE and busy = 0;
- ack_a = ack_b = 0;
- ram_wr = ram_rd = 0, ram_add = 0, ram_data_in = 0;
- rdata_a = rdata_b = 0;
- round-robin pointer set so that port A wins the first contention.
REQ-029 Reset during ACCESS or RESP aborts the transaction.
- No ack is issued.
- ram_wr drops asynchronously; a write in progress is not guaranteed to commit.
REQ-030 Operation resumes in IDLE on the first posedge after rst is released.

Verification
REQ-031 Reset, then A writes 0x5A to address 3 -> ram_wr=1, ram_add=3, ram_data_in=0x5A in cycle N+1; ack_a in N+2; busy high for 2 cycles.
REQ-032 A reads address 3 after REQ-031 -> ram_rd=1 in N+1; ack_a with rdata_a=0x5A in N+2; rdata_b stays 0.
REQ-033 req_a and req_b both held continuously right after reset, each a read of a distinct address -> grant order A, B, A, B; acks 3 cycles apart; never both acks high.
REQ-034 B writes 0xFF to address 7 while req_a rises during B's ACCESS -> B completes first; A is granted in the IDLE cycle following ack_b.
REQ-035 rst asserted mid-ACCESS of a write of 0x11 to address 0 -> ram_wr, busy and acks go 0 without a clock edge; no ack follows; the FSM is in IDLE after release.
REQ-036 Write then read every address 0..7 with pattern 8'hA0+address -> every read returns its pattern; address wrap covered at 7.
